exe_mem_stage: RTL
==================

Name: exe_mem_stage

Overview:
- Execute stage of the 5-stage pipelined CPU; consumes the ID/EXE pipeline register outputs and produces the EXE/MEM pipeline register.
- Single-cycle ALU ops: and, or, add, sub, slt, nor.
- Multi-cycle iterative MUL: asserts `stall` to freeze IF, ID and ID/EXE, and inserts bubbles into EXE/MEM until the product is ready.

Parameters:
- DATA_W, 32, datapath width.
- MUL_STEPS, 1, multiplier bits retired per BUSY cycle; must divide DATA_W. N = DATA_W/MUL_STEPS.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- e_valid  in  1  ID/EXE holds a real instruction (0 = bubble).
- ewreg  in  1  register-write control.
- em2reg  in  1  load-select control.
- ewmem  in  1  memory-write control.
- ealuc  in  4  ALU op code.
- ealuimm  in  1  ALU B-operand select: 1 = eimm32, 0 = eqb.
- edestReg  in  5  destination register.
- eqa  in  DATA_W  operand A.
- eqb  in  DATA_W  operand B / store data.
- eimm32  in  DATA_W  sign-extended immediate.
- stall  out  1  combinational; holds IF, ID and ID/EXE.
- m_valid  out  1  EXE/MEM valid.
- mwreg  out  1  EXE/MEM register-write control.
- mm2reg  out  1  EXE/MEM load-select control.
- mwmem  out  1  EXE/MEM memory-write control.
- mdestReg  out  5  EXE/MEM destination register.
- mr  out  DATA_W  ALU result.
- mqb  out  DATA_W  store data (eqb passthrough).

Behaviour:
- Reset (resetn=0 at a rising edge): all outputs 0; state IDLE; counter 0; multiplier registers 0.
- Reset mid-multiply aborts the operation; no result is ever written.
- stall is forced to 0 while resetn=0.
- Operand B: b = ealuimm ? eimm32 : eqb.
- ALU codes:
  - 0000 = a & b
  - 0001 = a | b
  - 0010 = a + b
  - 0110 = a - b
  - 0111 = signed(a) < signed(b) ? 1 : 0
  - 1100 = ~(a | b)
  - 1000 = MUL, low DATA_W bits of a*b
  - Any other code: mr = 0; controls pass through.
- Add, sub and mul wrap mod 2^DATA_W; no overflow flag.
- IDLE, non-MUL, or e_valid=0 (latency 1): at the rising edge, EXE/MEM loads:
  - m_valid = e_valid; mwreg = ewreg & e_valid; mwmem = ewmem & e_valid.
  - mm2reg, mdestReg, mqb = eqb and mr = ALU result load unconditionally.
  - stall = 0.
- IDLE with e_valid=1 and ealuc=1000 (issue cycle):
  - stall = 1.
  - Capture a, b, edestReg, ewreg, em2reg, ewmem, eqb into the multiplier.
  - Load a bubble into EXE/MEM: m_valid = mwreg = mwmem = 0, other fields hold.
  - state -> BUSY, counter = 0.
- BUSY:
  - Each cycle retires MUL_STEPS shift-add bits; counter increments.
  - Inputs from ID/EXE are ignored.
  - While counter < N-1: stall = 1 and EXE/MEM receives bubbles.
  - When counter = N-1: stall = 0 and EXE/MEM loads the captured controls with mr = product, m_valid = 1; state -> IDLE.
  - At that same edge ID/EXE advances, so the next instruction is presented in IDLE.
- MUL timing: occupies N+1 cycles and inserts N bubbles. Product appears on mr after the (N+1)th rising edge counted from its first presentation.
- Back-to-back MULs: the second MUL is detected in IDLE on the cycle after completion and issues normally. No bubble beyond the N bubbles per MUL.

Decomposition:
- Package exe_pkg: ALUC_AND, ALUC_OR, ALUC_ADD, ALUC_SUB, ALUC_SLT, ALUC_NOR, ALUC_MUL constants (4-bit); state encoding ST_IDLE / ST_BUSY.
- One sub-module mul_iter: start, busy and done handshake plus product output; parameterised by DATA_W and MUL_STEPS.
- The combinational ALU and the EXE/MEM register stay in exe_mem_stage.

Test Plan:
- resetn=0 for 2 cycles with random inputs -> all outputs 0, stall=0.
- After the release edge, add with eqa=5, eqb=7, ealuimm=0, edestReg=3, ewreg=1 -> next edge: mr=12, mdestReg=3, mwreg=1, m_valid=1.
- lw: eqa=0x100, eimm32=0xFFFFFFFC, ealuimm=1, em2reg=1 -> mr=0xFC, mm2reg=1.
- sub 3-5 -> mr=0xFFFFFFFE.
- slt with eqa=0xFFFFFFFF, eqb=1 -> mr=1.
- nor 0,0 -> 0xFFFFFFFF.
- aluc=0101 -> mr=0.
- MUL 6*7, N=32:
  - stall=1 for exactly 32 cycles.
  - m_valid=0 on the 32 edges after issue.
  - The 33rd edge gives mr=42, m_valid=1.
  - The next instruction is registered one edge later.
- MUL 0xFFFFFFFF*2 -> mr=0xFFFFFFFE.
- Reset asserted at BUSY counter=10 -> after the edge: IDLE, stall=0, m_valid=0; no product is written later.
- e_valid=0 with ewreg=1, ewmem=1 -> mwreg=0, mwmem=0, m_valid=0, stall=0.
- MUL with e_valid=0 -> no stall.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU op codes, multiplier FSM states
// and the control bundle captured while a MUL is in flight.
package exe_pkg;
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_NOR = 4'b1100;
  localparam logic [3:0] ALUC_MUL = 4'b1000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] dest;
  } mul_ctl_t;
endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEPS multiplier bits per BUSY
// cycle; product_o is valid (next accumulator value) while done_o is high.
module mul_iter
  import exe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);
  localparam int N     = DATA_W / MUL_STEPS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] partial, acc_nxt;

  assign busy_o    = (state_q == ST_BUSY);
  assign done_o    = busy_o && (cnt_q == CNT_W'(N - 1));
  assign product_o = acc_nxt;

  // Only the low DATA_W bits survive, so partials shifted past the top drop out.
  always_comb begin
    partial = '0;
    for (int k = 0; k < MUL_STEPS; k++)
      if (mplier_q[k]) partial = partial + (mcand_q << k);
    acc_nxt = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d  = ST_BUSY;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = a_i;
        mplier_d = b_i;
      end
      default: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << MUL_STEPS;
        mplier_d = mplier_q >> MUL_STEPS;
        if (done_o) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL, feeding the EXE/MEM
// pipeline register; stalls the front end while a MUL is in flight.
module exe_mem_stage
  import exe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              e_valid,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic [3:0]        ealuc,
  input  logic              ealuimm,
  input  logic [4:0]        edestReg,
  input  logic [DATA_W-1:0] eqa,
  input  logic [DATA_W-1:0] eqb,
  input  logic [DATA_W-1:0] eimm32,
  output logic              stall,
  output logic              m_valid,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [4:0]        mdestReg,
  output logic [DATA_W-1:0] mr,
  output logic [DATA_W-1:0] mqb
);
  logic              busy, done, issue;
  logic [DATA_W-1:0] b_op, alu_res, product;

  mul_ctl_t          cap_q, cap_d;
  logic [DATA_W-1:0] cap_qb_q, cap_qb_d;

  logic              m_valid_q, m_valid_d, mwreg_q, mwreg_d;
  logic              mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
  logic [4:0]        mdest_q, mdest_d;
  logic [DATA_W-1:0] mr_q, mr_d, mqb_q, mqb_d;

  assign b_op  = ealuimm ? eimm32 : eqb;
  assign issue = !busy && e_valid && (ealuc == ALUC_MUL);
  assign stall = resetn && (issue || (busy && !done));

  // MUL is not produced here; unknown codes (and an invalid MUL) yield zero.
  always_comb begin
    alu_res = '0;
    case (ealuc)
      ALUC_AND: alu_res = eqa & b_op;
      ALUC_OR:  alu_res = eqa | b_op;
      ALUC_ADD: alu_res = eqa + b_op;
      ALUC_SUB: alu_res = eqa - b_op;
      ALUC_SLT: alu_res = DATA_W'($signed(eqa) < $signed(b_op));
      ALUC_NOR: alu_res = ~(eqa | b_op);
      default:  alu_res = '0;
    endcase
  end

  mul_iter #(.DATA_W(DATA_W), .MUL_STEPS(MUL_STEPS)) u_mul (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (issue),
    .a_i       (eqa),
    .b_i       (b_op),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  always_comb begin
    cap_d     = cap_q;
    cap_qb_d  = cap_qb_q;
    m_valid_d = m_valid_q;
    mwreg_d   = mwreg_q;
    mm2reg_d  = mm2reg_q;
    mwmem_d   = mwmem_q;
    mdest_d   = mdest_q;
    mr_d      = mr_q;
    mqb_d     = mqb_q;
    if (busy) begin
      if (done) begin
        m_valid_d = 1'b1;
        mwreg_d   = cap_q.wreg;
        mm2reg_d  = cap_q.m2reg;
        mwmem_d   = cap_q.wmem;
        mdest_d   = cap_q.dest;
        mr_d      = product;
        mqb_d     = cap_qb_q;
      end else begin
        m_valid_d = 1'b0;
        mwreg_d   = 1'b0;
        mwmem_d   = 1'b0;
      end
    end else if (issue) begin
      cap_d     = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem, dest: edestReg};
      cap_qb_d  = eqb;
      m_valid_d = 1'b0;
      mwreg_d   = 1'b0;
      mwmem_d   = 1'b0;
    end else begin
      m_valid_d = e_valid;
      mwreg_d   = ewreg & e_valid;
      mwmem_d   = ewmem & e_valid;
      mm2reg_d  = em2reg;
      mdest_d   = edestReg;
      mr_d      = alu_res;
      mqb_d     = eqb;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_q     <= '0;
      cap_qb_q  <= '0;
      m_valid_q <= 1'b0;
      mwreg_q   <= 1'b0;
      mm2reg_q  <= 1'b0;
      mwmem_q   <= 1'b0;
      mdest_q   <= '0;
      mr_q      <= '0;
      mqb_q     <= '0;
    end else begin
      cap_q     <= cap_d;
      cap_qb_q  <= cap_qb_d;
      m_valid_q <= m_valid_d;
      mwreg_q   <= mwreg_d;
      mm2reg_q  <= mm2reg_d;
      mwmem_q   <= mwmem_d;
      mdest_q   <= mdest_d;
      mr_q      <= mr_d;
      mqb_q     <= mqb_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign mwreg    = mwreg_q;
  assign mm2reg   = mm2reg_q;
  assign mwmem    = mwmem_q;
  assign mdestReg = mdest_q;
  assign mr       = mr_q;
  assign mqb      = mqb_q;
endmodule
